multicycle_control: RTL and testbench

Sequencing controller for the multi-cycle MIPS datapath. Walks each instruction through fetch, decode, execute, memory and write-back states, drives every datapath enable and mux select, and stalls on a memory ready handshake. Supported opcodes: R-type (0x00), addi (0x08), beq (0x04), j (0x02), lw (0x23), sw (0x2B); illegal opcodes are flagged and skipped.

---
 rtl/multicycle_control.sv | 178 +++++++++++++++++
 tb/tb_multicycle_control.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle MIPS datapath: steps each instruction through
// its fetch/decode/execute/memory/write-back states and drives all datapath controls.
module multicycle_control (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       en,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_2_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  state_t state_reg, state_next;
  state_t boundary_next;
  logic   illegal_reg, illegal_next;

  // Where every finished instruction goes: next fetch, or park when disabled.
  assign boundary_next = en ? S_FETCH : S_IDLE;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg   <= S_IDLE;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    illegal_next  = illegal_reg;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_2_reg     = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (en) state_next = S_FETCH;
      end
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // IR load and PC+4 only land on the cycle memory returns the word.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EX;
          default: begin
            illegal_next = 1'b1;
            instr_done   = 1'b1;
            state_next   = boundary_next;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_2_reg  = 1'b1;
        instr_done = 1'b1;
        state_next = boundary_next;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_next = boundary_next;
        end
      end
      S_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        state_next = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_next = boundary_next;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        state_next    = boundary_next;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
        state_next = boundary_next;
      end
      S_ADDI_EX: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        state_next = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_next = boundary_next;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign illegal_op = illegal_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised self-checking bench for multicycle_control: a per-opcode state-path and
// latency model plus the per-state output table, compared cycle by cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       arst_n, en, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write;
  logic       mem_2_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .arst_n(arst_n), .en(en), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_2_reg(mem_2_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
    .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J = 6'h02, OP_LW = 6'h23, OP_SW = 6'h2B;

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit order: [15]pc_write [14]pc_write_cond [13]ir_write [12]i_or_d [11]mem_read
  // [10]mem_write [9]mem_2_reg [8]reg_dst [7]reg_write [6]alu_src_a [5:4]alu_src_b
  // [3:2]alu_op [1:0]pc_source
  logic [15:0] obs_vec;
  assign obs_vec = {pc_write, pc_write_cond, ir_write, i_or_d, mem_read, mem_write,
                    mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  logic [3:0]  o_state[$], e_state[$];
  logic [15:0] o_out[$], e_out[$];
  logic        o_done[$], e_done[$], o_ill[$], e_ill[$], o_mr[$];
  int          done_cyc[$];
  bit          model_ill = 1'b0;

  // Latency from FETCH to instr_done inclusive, with no memory stalls.
  function automatic int path_len(input logic [5:0] op);
    case (op)
      OP_LW:                      return 5;
      OP_SW, OP_R, OP_ADDI:       return 4;
      OP_BEQ, OP_J:               return 3;
      default:                    return 2;
    endcase
  endfunction

  function automatic logic [3:0] path_state(input logic [5:0] op, input int idx);
    logic [3:0] p[5];
    p = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd0};
    case (op)
      OP_LW:   p = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      OP_SW:   p = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd0};
      OP_R:    p = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd0};
      OP_BEQ:  p = '{4'd1, 4'd2, 4'd9, 4'd0, 4'd0};
      OP_J:    p = '{4'd1, 4'd2, 4'd10, 4'd0, 4'd0};
      OP_ADDI: p = '{4'd1, 4'd2, 4'd11, 4'd12, 4'd0};
      default: ;
    endcase
    return p[idx];
  endfunction

  function automatic bit is_wait(input logic [3:0] st);
    return (st == 4'd1) || (st == 4'd4) || (st == 4'd6);
  endfunction

  function automatic logic [15:0] spec_out(input logic [3:0] st, input logic mr);
    logic pcw = 0, pwc = 0, irw = 0, iod = 0, mrd = 0, mwr = 0, m2r = 0, rdst = 0, rw = 0, sa = 0;
    logic [1:0] sb = 0, aop = 0, psrc = 0;
    case (st)
      4'd1:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      4'd2:  sb = 2'b11;
      4'd3:  begin sa = 1; sb = 2'b10; end
      4'd4:  begin mrd = 1; iod = 1; end
      4'd5:  begin rw = 1; m2r = 1; end
      4'd6:  begin mwr = 1; iod = 1; end
      4'd7:  begin sa = 1; aop = 2'b10; end
      4'd8:  begin rw = 1; rdst = 1; end
      4'd9:  begin sa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; end
      4'd10: begin pcw = 1; psrc = 2'b10; end
      4'd11: begin sa = 1; sb = 2'b10; end
      4'd12: rw = 1;
      default: ;
    endcase
    return {pcw, pwc, irw, iod, mrd, mwr, m2r, rdst, rw, sa, sb, aop, psrc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic record(input logic [3:0] es, input logic ed);
    o_state.push_back(state);
    o_out.push_back(obs_vec);
    o_done.push_back(instr_done);
    o_ill.push_back(illegal_op);
    o_mr.push_back(mem_ready);
    e_state.push_back(es);
    e_out.push_back(spec_out(es, mem_ready));
    e_done.push_back(ed);
    e_ill.push_back(model_ill);
    if (instr_done === 1'b1) done_cyc.push_back(cyc);
    if (es == 4'd2 && path_len(opcode) == 2) model_ill = 1'b1;
  endtask

  // Runs one instruction from a FETCH cycle; en drops from path index drop_idx onward.
  task automatic run_instr(input logic [5:0] op, input int fetch_stall,
                           input int mem_stall, input int drop_idx);
    int n, stall;
    logic [3:0] es;
    o_state.delete(); o_out.delete(); o_done.delete(); o_ill.delete(); o_mr.delete();
    e_state.delete(); e_out.delete(); e_done.delete(); e_ill.delete();
    opcode = op;
    n = path_len(op);
    for (int i = 0; i < n; i++) begin
      es = path_state(op, i);
      en = (i >= drop_idx) ? 1'b0 : 1'b1;
      stall = (es == 4'd1) ? fetch_stall : (is_wait(es) ? mem_stall : 0);
      for (int k = 0; k <= stall; k++) begin
        if (is_wait(es)) mem_ready = (k == stall);
        else mem_ready = 1'($urandom_range(0, 1));
        #1;
        record(es, (i == n - 1) && (k == stall));
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    arst_n = 1'b0; en = 1'b1; mem_ready = 1'b0; opcode = 6'h00;
    model_ill = 1'b0;
    step(); step();
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if ({obs_vec, instr_done, illegal_op} !== 18'd0) begin failures++;
      $display("FAIL reset_outputs got=%h exp=0", {obs_vec, instr_done, illegal_op}); end
    en = 1'b0; arst_n = 1'b1;
    step(); step();
    checks++; if (state !== 4'd0) begin failures++; $display("FAIL idle_park got=%0d exp=0", state); end
    en = 1'b1;
    step();
    checks++; if (state !== 4'd1) begin failures++; $display("FAIL first_fetch got=%0d exp=1", state); end
  endtask

  task automatic test_lw_sequence();
    run_instr(OP_LW, 0, 0, 99);
    for (int c = 0; c < 5; c++) begin
      checks++; if (o_state[c] !== e_state[c] || o_done[c] !== (c == 4)) begin failures++;
        $display("FAIL lw_seq c=%0d got state=%0d done=%b exp state=%0d done=%b",
                 c, o_state[c], o_done[c], e_state[c], (c == 4)); end
    end
    checks++; if (state !== 4'd1) begin failures++; $display("FAIL lw_next got=%0d exp=1", state); end
  endtask

  task automatic test_sw_stall();
    int wr_cycles = 0;
    bit rw_seen = 0;
    run_instr(OP_SW, 0, 3, 99);
    foreach (o_out[c]) begin
      if (o_out[c][10] && o_out[c][12]) wr_cycles++;
      if (o_out[c][7]) rw_seen = 1;
    end
    checks++; if (wr_cycles != 4) begin failures++; $display("FAIL sw_hold got=%0d exp=4", wr_cycles); end
    checks++; if (rw_seen) begin failures++; $display("FAIL sw_reg_write got=1 exp=0"); end
    checks++; if (o_state.size() != 7 || o_done[6] !== 1'b1 || o_mr[6] !== 1'b1 || o_done[5] !== 1'b0)
      begin failures++; $display("FAIL sw_done len=%0d exp=7 done_last=%b exp=1", o_state.size(), o_done[o_done.size()-1]); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seq[3];
    int lat[3];
    seq = '{OP_R, OP_BEQ, OP_J};
    lat = '{4, 3, 3};
    done_cyc.delete();
    for (int s = 0; s < 3; s++) begin
      run_instr(seq[s], 0, 0, 99);
      checks++; if (o_state.size() != lat[s] || o_done[lat[s]-1] !== 1'b1) begin failures++;
        $display("FAIL b2b_len op=%h got=%0d exp=%0d", seq[s], o_state.size(), lat[s]); end
      foreach (o_state[c]) begin
        if (o_state[c] == 4'd9) begin
          checks++; if (o_out[c][14] !== 1'b1 || o_out[c][3:2] !== 2'b01) begin failures++;
            $display("FAIL branch_out got=%h exp pwc=1 alu_op=01", o_out[c]); end
        end
        if (o_state[c] == 4'd10) begin
          checks++; if (o_out[c][15] !== 1'b1 || o_out[c][1:0] !== 2'b10) begin failures++;
            $display("FAIL jump_out got=%h exp pcw=1 psrc=10", o_out[c]); end
        end
      end
    end
    checks++; if (done_cyc.size() != 3 || done_cyc[1] - done_cyc[0] != 3 || done_cyc[2] - done_cyc[1] != 3)
      begin failures++; $display("FAIL b2b_spacing got n=%0d exp 3 pulses 3 apart", done_cyc.size()); end
  endtask

  task automatic test_fetch_stall();
    int irw = 0, pcw = 0;
    run_instr(OP_ADDI, 2, 0, 99);
    foreach (o_out[c]) begin
      if (o_out[c][13]) irw++;
      if (o_out[c][15]) pcw++;
    end
    checks++; if (irw != 1 || pcw != 1) begin failures++;
      $display("FAIL fetch_stall_pulses got ir=%0d pc=%0d exp 1 1", irw, pcw); end
    checks++; if (o_out[2][13] !== 1'b1 || o_state[2] !== 4'd1 || o_mr[2] !== 1'b1) begin failures++;
      $display("FAIL fetch_stall_when got=%h state=%0d exp ir_write in 3rd FETCH cycle", o_out[2], o_state[2]); end
    checks++; if (o_state.size() != 6 || o_done[5] !== 1'b1) begin failures++;
      $display("FAIL fetch_stall_len got=%0d exp=6", o_state.size()); end
  endtask

  task automatic test_en_drop();
    run_instr(OP_R, 0, 0, 2);
    checks++; if (o_done[3] !== 1'b1 || o_state[3] !== 4'd8) begin failures++;
      $display("FAIL en_drop_complete got state=%0d done=%b exp 8 1", o_state[3], o_done[3]); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (state !== 4'd0 || obs_vec !== 16'd0 || instr_done !== 1'b0) begin failures++;
        $display("FAIL en_drop_idle got state=%0d out=%h exp 0 0", state, obs_vec); end
      step();
    end
    en = 1'b1;
    step();
    checks++; if (state !== 4'd1) begin failures++; $display("FAIL en_resume got=%0d exp=1", state); end
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 0, 0, 99);
    checks++; if (o_state.size() != 2 || o_state[1] !== 4'd2 || o_done[1] !== 1'b1 || o_ill[1] !== 1'b0)
      begin failures++; $display("FAIL illegal_decode got state=%0d done=%b ill=%b exp 2 1 0", o_state[1], o_done[1], o_ill[1]); end
    checks++; if (illegal_op !== 1'b1 || state !== 4'd1) begin failures++;
      $display("FAIL illegal_set got ill=%b state=%0d exp 1 1", illegal_op, state); end
    run_instr(OP_ADDI, 0, 0, 99);
    checks++; if (o_state.size() != 4 || o_done[3] !== 1'b1) begin failures++;
      $display("FAIL illegal_then_addi got len=%0d exp=4", o_state.size()); end
    checks++; if (illegal_op !== 1'b1 || o_ill[3] !== 1'b1) begin failures++;
      $display("FAIL illegal_sticky got=%b exp=1", illegal_op); end
  endtask

  task automatic test_async_reset();
    en = 1'b1; opcode = OP_LW; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    #1;
    checks++; if (state !== 4'd4 || mem_read !== 1'b1) begin failures++;
      $display("FAIL pre_reset got state=%0d mem_read=%b exp 4 1", state, mem_read); end
    #1 arst_n = 1'b0;
    #1;
    checks++; if (state !== 4'd0 || obs_vec !== 16'd0 || illegal_op !== 1'b0) begin failures++;
      $display("FAIL async_reset got state=%0d out=%h ill=%b exp 0 0 0", state, obs_vec, illegal_op); end
    model_ill = 1'b0;
    step();
    arst_n = 1'b1;
    step();
    checks++; if (state !== 4'd1) begin failures++; $display("FAIL post_reset_fetch got=%0d exp=1", state); end
  endtask

  task automatic test_random();
    logic [5:0] ops[8];
    logic [5:0] op;
    int drop;
    ops = '{OP_R, OP_ADDI, OP_BEQ, OP_J, OP_LW, OP_SW, 6'h3F, 6'h11};
    for (int t = 0; t < 40; t++) begin
      op = ops[$urandom_range(0, 7)];
      drop = ($urandom_range(0, 5) == 0) ? $urandom_range(1, path_len(op) - 1) : 99;
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), drop);
      for (int c = 0; c < o_state.size(); c++) begin
        checks++; if (o_state[c] !== e_state[c]) begin failures++;
          $display("FAIL rnd_state op=%h c=%0d got=%0d exp=%0d", op, c, o_state[c], e_state[c]); end
        checks++; if (o_out[c] !== e_out[c]) begin failures++;
          $display("FAIL rnd_out op=%h c=%0d got=%h exp=%h", op, c, o_out[c], e_out[c]); end
        checks++; if (o_done[c] !== e_done[c] || o_ill[c] !== e_ill[c]) begin failures++;
          $display("FAIL rnd_done_ill op=%h c=%0d got=%b%b exp=%b%b", op, c, o_done[c], o_ill[c], e_done[c], e_ill[c]); end
        checks++; if ((o_out[c][10] && o_out[c][7]) ||
                      ((o_out[c][15] || o_out[c][13]) && !((o_state[c] == 4'd1 && o_mr[c]) || (o_state[c] == 4'd10 && !o_out[c][13]))))
          begin failures++; $display("FAIL rnd_strobe_rule op=%h c=%0d got=%h state=%0d", op, c, o_out[c], o_state[c]); end
      end
      if (drop != 99) begin
        checks++; if (state !== 4'd0) begin failures++; $display("FAIL rnd_park got=%0d exp=0", state); end
        en = 1'b1;
        step();
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw_sequence();
    test_sw_stall();
    test_back_to_back();
    test_fetch_stall();
    test_en_drop();
    test_illegal();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
